// File: rtl/ctrl_transfer_unit.sv
// ctrl_transfer_unit
//   Executes GOTO / IF_xx / CALL / RET for the processor control FSM.
//   Fetches the branch target byte from data memory (synchronous RAM,
//   1-cycle latency), evaluates the signed condition on temp1 and keeps an
//   internal return-address stack.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   start, op        one-cycle request (sampled in IDLE) and opcode
//   ip_in, temp1     operand-byte address and signed condition operand
//   mem_rd, mem_addr data-memory read strobe / address
//   mem_q            data-memory read data
//   done, ip_out     one-cycle completion pulse with next ip
//   busy             high whenever not IDLE
//   empty, full      return-stack status
//   stack_err        sticky overflow/underflow flag
//
// Optional build macro: CTU_TRAP_EN -- stack over/underflow vectors to
// TRAP_ADDR instead of falling through to ip+1.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for start; captures op/ip/temp1
// MEM_READ | mem_rd asserted at the latched ip
// MEM_WAIT | RAM data valid; register it as the target
// RESOLVE  | evaluate condition, push/pop, compute next ip
// JMP_NEXT | done pulse, ip_out valid
module ctrl_transfer_unit #(
    parameter int             AW        = 8,
    parameter int             DEPTH     = 8,
    parameter logic [AW-1:0]  TRAP_ADDR = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] ip_in,
    input  logic [7:0]    temp1,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_q,
    output logic          done,
    output logic [AW-1:0] ip_out,
    output logic          busy,
    output logic          empty,
    output logic          full,
    output logic          stack_err
);

    localparam int SPW = $clog2(DEPTH) + 1;

    localparam logic [2:0] OP_GOTO = 3'd0;
    localparam logic [2:0] OP_LT   = 3'd1;
    localparam logic [2:0] OP_GT   = 3'd2;
    localparam logic [2:0] OP_EQ   = 3'd3;
    localparam logic [2:0] OP_GE   = 3'd4;
    localparam logic [2:0] OP_LE   = 3'd5;
    localparam logic [2:0] OP_CALL = 3'd6;
    localparam logic [2:0] OP_RET  = 3'd7;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MEM_READ = 3'd1,
        MEM_WAIT = 3'd2,
        RESOLVE  = 3'd3,
        JMP_NEXT = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [AW-1:0]   ip_q, ip_d;
    logic [7:0]      temp1_q, temp1_d;
    logic [AW-1:0]   target_q, target_d;
    logic [SPW-1:0]  sp_q, sp_d;
    logic            stack_err_q, stack_err_d;
    logic [AW-1:0]   ip_out_q, ip_out_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;

    logic [AW-1:0]   stack_mem [DEPTH];
    logic            push_en;
    logic [SPW-2:0]  pop_idx;
    logic [AW-1:0]   ip_inc;
    logic [AW-1:0]   fault_ip;
    logic            t_neg, t_zero, taken;

    assign ip_inc  = ip_q + AW'(1);
    assign pop_idx = sp_q[SPW-2:0] - 1'b1;
    assign t_neg   = temp1_q[7];
    assign t_zero  = (temp1_q == 8'd0);

`ifdef CTU_TRAP_EN
    assign fault_ip = TRAP_ADDR;
`else
    assign fault_ip = ip_inc;
`endif

    assign empty     = (sp_q == '0);
    assign full      = (sp_q == SPW'(DEPTH));
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == JMP_NEXT);
    assign mem_rd    = (state_q == MEM_READ);
    assign mem_addr  = mem_addr_q;
    assign ip_out    = ip_out_q;
    assign stack_err = stack_err_q;

    always_comb begin
        unique case (op_q)
            OP_GOTO: taken = 1'b1;
            OP_LT:   taken = t_neg;
            OP_GT:   taken = !t_neg && !t_zero;
            OP_EQ:   taken = t_zero;
            OP_GE:   taken = !t_neg;
            OP_LE:   taken = t_neg || t_zero;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ip_d        = ip_q;
        temp1_d     = temp1_q;
        target_d    = target_q;
        sp_d        = sp_q;
        stack_err_d = stack_err_q;
        ip_out_d    = ip_out_q;
        mem_addr_d  = mem_addr_q;
        push_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    ip_d    = ip_in;
                    temp1_d = temp1;
                    if (op == OP_RET) begin
                        state_d = RESOLVE;
                    end else begin
                        state_d    = MEM_READ;
                        mem_addr_d = ip_in;
                    end
                end
            end
            MEM_READ: state_d = MEM_WAIT;
            MEM_WAIT: begin
                target_d = AW'(mem_q);
                state_d  = RESOLVE;
            end
            RESOLVE: begin
                state_d = JMP_NEXT;
                if (op_q == OP_CALL) begin
                    if (!full) begin
                        push_en  = 1'b1;
                        sp_d     = sp_q + SPW'(1);
                        ip_out_d = target_q;
                    end else begin
                        stack_err_d = 1'b1;
                        ip_out_d    = fault_ip;
                    end
                end else if (op_q == OP_RET) begin
                    if (!empty) begin
                        sp_d     = sp_q - SPW'(1);
                        ip_out_d = stack_mem[pop_idx];
                    end else begin
                        stack_err_d = 1'b1;
                        ip_out_d    = fault_ip;
                    end
                end else begin
                    ip_out_d = taken ? target_q : ip_inc;
                end
            end
            JMP_NEXT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            ip_q        <= '0;
            temp1_q     <= 8'd0;
            target_q    <= '0;
            sp_q        <= '0;
            stack_err_q <= 1'b0;
            ip_out_q    <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ip_q        <= ip_d;
            temp1_q     <= temp1_d;
            target_q    <= target_d;
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
            ip_out_q    <= ip_out_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // Stack storage is not reset; a reset during RESOLVE must not push.
    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            stack_mem[sp_q[SPW-2:0]] <= ip_inc;
        end
    end

endmodule

// File: tb/tb_ctrl_transfer_unit.sv
// Directed testbench for ctrl_transfer_unit: vector table for the
// condition/target logic plus hand-written stack and reset sequences.
module tb_ctrl_transfer_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] ip_in;
    logic [7:0] temp1;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_q = 8'd0;
    logic       done;
    logic [7:0] ip_out;
    logic       busy;
    logic       empty;
    logic       full;
    logic       stack_err;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_q <= mem[mem_addr];
    end

    ctrl_transfer_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .ip_in(ip_in),
        .temp1(temp1), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q),
        .done(done), .ip_out(ip_out), .busy(busy), .empty(empty),
        .full(full), .stack_err(stack_err)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] ip;
        logic [7:0] t;
        logic [7:0] m;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[15];

    function automatic logic [7:0] fault_ip(input logic [7:0] ip);
`ifdef CTU_TRAP_EN
        return 8'hFF;
`else
        return ip + 8'd1;
`endif
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Called #1 after a posedge with the DUT idle; returns in the cycle after done.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [7:0] ip,
                          input logic [7:0] t, input logic [7:0] exp_ip);
        int cyc = 0;
        bit seen = 0;
        int exp_lat = (o == 3'd7) ? 2 : 4;
        start = 1'b1; op = o; ip_in = ip; temp1 = t;
        while (!seen && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            op = 3'($urandom); ip_in = 8'($urandom); temp1 = 8'($urandom);
            if (cyc == 1 && o != 3'd7) begin
                check({nm, " mem_rd"}, int'(mem_rd), 1);
                check({nm, " mem_addr"}, int'(mem_addr), int'(ip));
            end
            if (done) seen = 1;
        end
        check({nm, " latency"}, cyc, exp_lat);
        check({nm, " ip_out"}, int'(ip_out), int'(exp_ip));
        @(posedge clk); #1;
        check({nm, " done pulse"}, int'(done), 0);
        check({nm, " busy"}, int'(busy), 0);
    endtask

    initial begin
        vt[0]  = '{3'd0, 8'd25,  8'd0,    8'd26,  8'd26};
        vt[1]  = '{3'd1, 8'd22,  8'hFD,   8'd23,  8'd23};
        vt[2]  = '{3'd1, 8'd22,  8'd5,    8'd23,  8'd23};
        vt[3]  = '{3'd1, 8'd22,  8'hFD,   8'd60,  8'd60};
        vt[4]  = '{3'd1, 8'd22,  8'd5,    8'd60,  8'd23};
        vt[5]  = '{3'd4, 8'd10,  8'd0,    8'd40,  8'd40};
        vt[6]  = '{3'd5, 8'd10,  8'd0,    8'd40,  8'd40};
        vt[7]  = '{3'd2, 8'd30,  8'd0,    8'd90,  8'd31};
        vt[8]  = '{3'd2, 8'd30,  8'd1,    8'd90,  8'd90};
        vt[9]  = '{3'd3, 8'd5,   8'd0,    8'd77,  8'd77};
        vt[10] = '{3'd3, 8'd5,   8'hFF,   8'd77,  8'd6};
        vt[11] = '{3'd4, 8'h70,  8'h80,   8'h11,  8'h71};
        vt[12] = '{3'd5, 8'h70,  8'h7F,   8'h11,  8'h71};
        vt[13] = '{3'd2, 8'h70,  8'h7F,   8'h11,  8'h11};
        vt[14] = '{3'd1, 8'hFF,  8'd1,    8'h55,  8'h00};

        reset = 1'b1; start = 1'b0; op = 3'd0; ip_in = 8'd0; temp1 = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst done", int'(done), 0);
        check("rst mem_rd", int'(mem_rd), 0);
        check("rst busy", int'(busy), 0);
        check("rst empty", int'(empty), 1);
        check("rst full", int'(full), 0);
        check("rst stack_err", int'(stack_err), 0);
        check("rst ip_out", int'(ip_out), 0);
        check("rst mem_addr", int'(mem_addr), 0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            mem[vt[i].ip] = vt[i].m;
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].ip, vt[i].t, vt[i].exp);
        end

        // CALL then RET
        mem[48] = 8'd65;
        run_op("call48", 3'd6, 8'd48, 8'd0, 8'd65);
        check("call48 empty", int'(empty), 0);
        run_op("ret", 3'd7, 8'd3, 8'd0, 8'd49);
        check("ret empty", int'(empty), 1);
        check("ret stack_err", int'(stack_err), 0);

        // Fill the stack, overflow, drain, underflow
        for (int i = 0; i < 8; i++) begin
            mem[100 + i] = 8'(200 + i);
            run_op($sformatf("fill%0d", i), 3'd6, 8'(100 + i), 8'd0, 8'(200 + i));
        end
        check("fill full", int'(full), 1);
        check("fill stack_err", int'(stack_err), 0);
        mem[120] = 8'd7;
        run_op("overflow", 3'd6, 8'd120, 8'd0, fault_ip(8'd120));
        check("overflow stack_err", int'(stack_err), 1);
        check("overflow full", int'(full), 1);
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("drain%0d", i), 3'd7, 8'd9, 8'd0, 8'(108 - i));
        end
        check("drain empty", int'(empty), 1);
        run_op("underflow", 3'd7, 8'd50, 8'd0, fault_ip(8'd50));
        check("underflow stack_err", int'(stack_err), 1);
        check("underflow empty", int'(empty), 1);

        // Reset during MEM_WAIT with a non-empty stack
        mem[60] = 8'd61;
        run_op("call60", 3'd6, 8'd60, 8'd0, 8'd61);
        check("call60 empty", int'(empty), 0);
        mem[25] = 8'd26;
        start = 1'b1; op = 3'd0; ip_in = 8'd25; temp1 = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst busy", int'(busy), 0);
        check("midrst empty", int'(empty), 1);
        check("midrst stack_err", int'(stack_err), 0);
        begin
            int seen_done = 0;
            for (int i = 0; i < 6; i++) begin
                if (done) seen_done++;
                @(posedge clk); #1;
            end
            check("midrst no done", seen_done, 0);
        end
        run_op("post-rst goto", 3'd0, 8'd25, 8'd0, 8'd26);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
